// File: rtl/aes_pkg.sv
// Shared AES definitions used by the round-stage engines: the state word width,
// the ShiftRows engine state encoding and the byte-position helper.
package aes_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_WAIT  = 3'd2,
        S_SHIFT = 3'd3,
        S_WR    = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6
    } srows_state_t;

    // Column-major byte position of state element (row r, column c).
    function automatic int byte_idx(input int r, input int c);
        return (32'sd4 * c) + r;
    endfunction

endpackage

// File: rtl/srows_multi_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation of one 128-bit state word.
// It is pure wiring plus a 2:1 select, so the cipher datapath can reuse it directly.
module srows_perm
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] din,
    input  logic                 inverse,
    output logic [AES_BLK_W-1:0] dout
);

    logic [AES_BLK_W-1:0] fwd_s;
    logic [AES_BLK_W-1:0] inv_s;

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            // Row r rotates left by r columns forward, right by r columns inverse.
            assign fwd_s[AES_BLK_W-1-8*byte_idx(r, c) -: 8] =
                din[AES_BLK_W-1-8*byte_idx(r, (c + r) % 4) -: 8];
            assign inv_s[AES_BLK_W-1-8*byte_idx(r, c) -: 8] =
                din[AES_BLK_W-1-8*byte_idx(r, (c + 4 - r) % 4) -: 8];
        end
    end

    assign dout = inverse ? inv_s : fwd_s;

endmodule

// File: rtl/srows_multi.sv
// Multi-block ShiftRows engine: walks NUM blocks of SRAM at a base address and stride,
// permuting each 128-bit word in place; handshakes with the round controller.
module srows_multi
    import aes_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int CNT_W       = 8,
    parameter int READ_LAT    = 2,
    parameter int ADDR_STRIDE = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 srows_enable,
    input  logic                 srows_inverse,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [CNT_W-1:0]     num_blocks,
    input  logic [AES_BLK_W-1:0] sramReadValue,
    output logic                 srows_busy,
    output logic                 srows_finished,
    output logic                 sramRead,
    output logic                 sramWrite,
    output logic [ADDR_W-1:0]    sramAddr,
    output logic [AES_BLK_W-1:0] sramWriteValue,
    output logic                 sramDump,
    output logic                 sramInit,
    output logic [2:0]           sramDumpNum,
    output logic [2:0]           sramInitNum
);

    localparam int WAIT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    srows_state_t         state_r;
    srows_state_t         next_s;
    logic                 inverse_r;
    logic [ADDR_W-1:0]    cur_addr_r;
    logic [CNT_W-1:0]     remaining_r;
    logic [WAIT_W-1:0]    wait_cnt_r;
    logic [AES_BLK_W-1:0] data_r;
    logic [AES_BLK_W-1:0] perm_s;
    logic                 busy_r;
    logic                 fin_r;
    logic                 rd_r;
    logic                 wr_r;
    logic [ADDR_W-1:0]    addr_r;

    srows_perm u_perm (
        .din     (sramReadValue),
        .inverse (inverse_r),
        .dout    (perm_s)
    );

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state decode; WAIT counts READ_LAT cycles because the strobe is registered.
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (srows_enable) begin
                    if (num_blocks == {CNT_W{1'b0}}) begin
                        next_s = S_DONE;
                    end else begin
                        next_s = S_RD;
                    end
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_RD:    next_s = S_WAIT;
            S_WAIT: begin
                if (wait_cnt_r == {WAIT_W{1'b0}}) begin
                    next_s = S_SHIFT;
                end else begin
                    next_s = S_WAIT;
                end
            end
            S_SHIFT: next_s = S_WR;
            S_WR:    next_s = S_NEXT;
            S_NEXT: begin
                if (remaining_r == CNT_W'(1)) begin
                    next_s = S_DONE;
                end else begin
                    next_s = S_RD;
                end
            end
            S_DONE:  next_s = S_IDLE;
            default: next_s = S_IDLE;
        endcase
    end

    // Run parameters, wait counter, address/count walk and result register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            inverse_r   <= 1'b0;
            cur_addr_r  <= {ADDR_W{1'b0}};
            remaining_r <= {CNT_W{1'b0}};
            wait_cnt_r  <= {WAIT_W{1'b0}};
            data_r      <= {AES_BLK_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (srows_enable) begin
                        inverse_r   <= srows_inverse;
                        cur_addr_r  <= base_addr;
                        remaining_r <= num_blocks;
                    end
                end
                S_RD:    wait_cnt_r <= WAIT_W'(READ_LAT - 1);
                S_WAIT: begin
                    if (wait_cnt_r != {WAIT_W{1'b0}}) begin
                        wait_cnt_r <= wait_cnt_r - WAIT_W'(1);
                    end
                end
                S_SHIFT: data_r <= perm_s;
                S_NEXT: begin
                    cur_addr_r  <= cur_addr_r + ADDR_W'(ADDR_STRIDE);
                    remaining_r <= remaining_r - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Registered bus and handshake outputs; busy also covers the accept cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            busy_r <= 1'b0;
            fin_r  <= 1'b0;
            rd_r   <= 1'b0;
            wr_r   <= 1'b0;
            addr_r <= {ADDR_W{1'b0}};
        end else begin
            busy_r <= (state_r != S_IDLE) || (next_s != S_IDLE);
            fin_r  <= (state_r == S_DONE);
            rd_r   <= (state_r == S_RD);
            wr_r   <= (state_r == S_WR);
            if (state_r == S_RD || state_r == S_WAIT || state_r == S_WR) begin
                addr_r <= cur_addr_r;
            end else begin
                addr_r <= {ADDR_W{1'b0}};
            end
        end
    end

    assign srows_busy     = busy_r;
    assign srows_finished = fin_r;
    assign sramRead       = rd_r;
    assign sramWrite      = wr_r;
    assign sramAddr       = addr_r;
    assign sramWriteValue = data_r;
    assign sramDump       = 1'b0;
    assign sramInit       = 1'b0;
    assign sramDumpNum    = 3'd0;
    assign sramInitNum    = 3'd0;

endmodule

// File: tb/tb_srows_multi.sv
// Randomised bench for srows_multi: SRAM model with read latency, access log and
// a byte-level ShiftRows reference computed straight from the row-rotation rule.
module tb_srows_multi;

    localparam int ADDR_W   = 16;
    localparam int CNT_W    = 8;
    localparam int READ_LAT = 2;
    localparam int STRIDE   = 16;

    logic               clk = 1'b0;
    logic               n_rst = 1'b0;
    logic               srows_enable = 1'b0;
    logic               srows_inverse = 1'b0;
    logic [ADDR_W-1:0]  base_addr = '0;
    logic [CNT_W-1:0]   num_blocks = '0;
    logic [127:0]       sramReadValue = '0;
    logic               srows_busy, srows_finished, sramRead, sramWrite;
    logic [ADDR_W-1:0]  sramAddr;
    logic [127:0]       sramWriteValue;
    logic               sramDump, sramInit;
    logic [2:0]         sramDumpNum, sramInitNum;

    srows_multi #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .READ_LAT(READ_LAT), .ADDR_STRIDE(STRIDE)) dut (
        .clk(clk), .n_rst(n_rst), .srows_enable(srows_enable), .srows_inverse(srows_inverse),
        .base_addr(base_addr), .num_blocks(num_blocks), .sramReadValue(sramReadValue),
        .srows_busy(srows_busy), .srows_finished(srows_finished), .sramRead(sramRead),
        .sramWrite(sramWrite), .sramAddr(sramAddr), .sramWriteValue(sramWriteValue),
        .sramDump(sramDump), .sramInit(sramInit), .sramDumpNum(sramDumpNum), .sramInitNum(sramInitNum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0] mem [logic [15:0]];
    logic [15:0]  rd_pend [int];
    logic [16:0]  acc_q [$];
    int           fin_q [$];
    int           both_cnt = 0;
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] sr_model(input logic [127:0] x, input logic inv);
        logic [7:0]   b [16];
        logic [127:0] y;
        int           src_c;
        for (int i = 0; i < 16; i++) b[i] = x[127-8*i -: 8];
        y = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                src_c = inv ? (c - r + 4) % 4 : (c + r) % 4;
                y[127-8*(4*c+r) -: 8] = b[4*src_c + r];
            end
        end
        return y;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // SRAM model: log accesses, apply writes, return read data READ_LAT cycles after the strobe.
    always @(negedge clk) begin
        if (sramRead && sramWrite) both_cnt++;
        if (sramRead) begin
            acc_q.push_back({1'b0, sramAddr});
            rd_pend[cyc + READ_LAT] = sramAddr;
        end
        if (sramWrite) begin
            acc_q.push_back({1'b1, sramAddr});
            mem[sramAddr] = sramWriteValue;
        end
        if (srows_finished) fin_q.push_back(cyc);
        if (rd_pend.exists(cyc)) begin
            sramReadValue = mem.exists(rd_pend[cyc]) ? mem[rd_pend[cyc]] : rnd128();
            rd_pend.delete(cyc);
        end else begin
            sramReadValue = rnd128();
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start(input logic inv, input logic [15:0] base, input logic [7:0] n, output int t0);
        acc_q.delete();
        fin_q.delete();
        srows_enable  = 1'b1;
        srows_inverse = inv;
        base_addr     = base;
        num_blocks    = n;
        t0            = cyc;
        tick();
        srows_enable  = 1'b0;
    endtask

    task automatic run_blocks(input logic inv, input logic [15:0] base, input logic [7:0] n, input bit noisy);
        logic [15:0]  a [$];
        logic [127:0] ev [$];
        int           t0, tfin;
        for (int i = 0; i < n; i++) begin
            a.push_back(base + 16'(STRIDE * i));
            if (!mem.exists(a[i])) mem[a[i]] = rnd128();
            ev.push_back(sr_model(mem[a[i]], inv));
        end
        tick();
        start(inv, base, n, t0);
        tfin = t0 + n * (READ_LAT + 4) + 2;
        chk("busy_after_accept", srows_busy, 1'b1);
        while (fin_q.size() == 0 && cyc < t0 + 2000) begin
            if (noisy && cyc < tfin - 1) begin
                srows_enable  = $urandom_range(1);
                srows_inverse = $urandom_range(1);
                base_addr     = $urandom;
                num_blocks    = $urandom;
            end else begin
                srows_enable = 1'b0;
            end
            tick();
        end
        srows_enable = 1'b0;
        chk("finished_seen", fin_q.size(), 1);
        if (fin_q.size() > 0) chk("finished_cycle", fin_q[0] - t0, tfin - t0);
        chk("busy_at_finish", srows_busy, 1'b1);
        tick();
        chk("busy_after_finish", srows_busy, 1'b0);
        chk("addr_idle", sramAddr, 16'h0000);
        repeat (3) tick();
        chk("single_finish", fin_q.size(), 1);
        chk("access_count", acc_q.size(), 2 * n);
        for (int i = 0; i < 2 * n && i < acc_q.size(); i++)
            chk($sformatf("access_%0d", i), acc_q[i], {i[0], a[i/2]});
        for (int i = 0; i < n; i++) chk($sformatf("result_%h", a[i]), mem[a[i]], ev[i]);
    endtask

    initial begin
        logic [127:0] vec_in, vec_out, orig0, orig1;
        int t0;
        vec_in  = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
        vec_out = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;

        repeat (3) tick();
        chk("rst_busy", srows_busy, 1'b0);
        chk("rst_finished", srows_finished, 1'b0);
        chk("rst_rd_wr", {sramRead, sramWrite}, 2'b00);
        chk("rst_addr", sramAddr, 16'h0000);
        chk("rst_wdata", sramWriteValue, 128'h0);
        chk("tie_offs", {sramDump, sramInit, sramDumpNum, sramInitNum}, 8'h00);
        n_rst = 1'b1;
        repeat (2) tick();

        mem[16'h0020] = vec_in;
        run_blocks(1'b0, 16'h0020, 8'd1, 1'b0);
        chk("fwd_vector", mem[16'h0020], vec_out);
        run_blocks(1'b1, 16'h0020, 8'd1, 1'b0);
        chk("inv_restores", mem[16'h0020], vec_in);

        run_blocks(1'b0, 16'h0100, 8'd3, 1'b0);
        run_blocks(1'b1, 16'h0300, 8'd0, 1'b0);
        run_blocks(1'b0, 16'hFFF0, 8'd2, 1'b0);

        for (int k = 0; k < 8; k++)
            run_blocks(1'($urandom_range(1)), 16'($urandom), 8'($urandom_range(1, 5)), 1'b1);

        // Abort with reset while block 2 is waiting on its read data.
        orig0 = rnd128();
        orig1 = rnd128();
        mem[16'h0200] = orig0;
        mem[16'h0210] = orig1;
        mem[16'h0220] = rnd128();
        tick();
        start(1'b0, 16'h0200, 8'd3, t0);
        while (cyc < t0 + READ_LAT + 7) tick();
        n_rst = 1'b0;
        #1;
        chk("abort_busy", srows_busy, 1'b0);
        chk("abort_rd_wr", {sramRead, sramWrite}, 2'b00);
        chk("abort_addr", sramAddr, 16'h0000);
        chk("abort_wdata", sramWriteValue, 128'h0);
        repeat (3) tick();
        n_rst = 1'b1;
        repeat (30) tick();
        chk("abort_accesses", acc_q.size(), 3);
        chk("abort_no_finish", fin_q.size(), 0);
        chk("abort_blk1_done", mem[16'h0200], sr_model(orig0, 1'b0));
        chk("abort_blk2_kept", mem[16'h0210], orig1);
        run_blocks(1'b0, 16'h0200, 8'd3, 1'b0);

        chk("rd_wr_never_together", both_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
